bitcount_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one shift-right bit-count engine between NUM_REQ requesters.
- Each requester presents a DATA_W-bit word. The arbiter grants one requester and drives that word into the engine. It then runs the engine's level start/done handshake and returns the count to the granted requester with a one-cycle valid pulse.
- Sits between the lab's lookup/datapath clients and the single bit-count engine.

---
 rtl/bitcount_arbiter_if.sv | 29 ++
 rtl/bitcount_arbiter.sv | 175 +++++++++++++++++
 tb/tb_bitcount_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/bitcount_arbiter_if.sv
// Requester and engine bus for bitcount_arbiter.
// The master modport is the arbiter; the slave modport is the requester/engine side.
interface bitcount_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RES_W   = 4
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [RES_W-1:0]          resp_result;
    logic                      resp_err;
    logic                      busy;
    logic                      eng_start;
    logic [DATA_W-1:0]         eng_value;
    logic [RES_W-1:0]          eng_result;
    logic                      eng_done;

    modport master (
        input  req, req_data, eng_result, eng_done,
        output grant, resp_valid, resp_result, resp_err, busy, eng_start, eng_value
    );

    modport slave (
        output req, req_data, eng_result, eng_done,
        input  grant, resp_valid, resp_result, resp_err, busy, eng_start, eng_value
    );
endinterface

// File: rtl/bitcount_arbiter.sv
// Round-robin arbiter sharing one bit-count engine between NUM_REQ requesters.
// Define BCARB_TIMEOUT_EN to add a RUN-state watchdog that reports resp_err.
module bitcount_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned RES_W          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic               clk,
    input  logic               reset,
    bitcount_arbiter_if.master bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << RES_W) <= DATA_W || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
            $error("bitcount_arbiter: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RELEASE} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [RES_W-1:0]   resp_result_q, resp_result_d;
    logic               eng_start_q, eng_start_d;
    logic [DATA_W-1:0]  eng_value_q, eng_value_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   winner_q, winner_d;
    logic               busy_q, busy_d;

    logic [DATA_W-1:0]  req_word [NUM_REQ];
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;

`ifdef BCARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             resp_err_q, resp_err_d;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
        assign req_word[g] = bus.req_data[g*DATA_W +: DATA_W];
    end

    // First set request after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && bus.req[IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        resp_valid_d  = '0;
        resp_result_d = resp_result_q;
        eng_start_d   = eng_start_q;
        eng_value_d   = eng_value_q;
        rr_ptr_d      = rr_ptr_q;
        winner_d      = winner_q;
`ifdef BCARB_TIMEOUT_EN
        tmo_d         = tmo_q;
        err_d         = err_q;
        resp_err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    winner_d    = win_idx;
                    grant_d     = NUM_REQ'(1) << win_idx;
                    eng_value_d = req_word[win_idx];
                    eng_start_d = 1'b0;
                    state_d     = LOAD;
`ifdef BCARB_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                end
            end
            // Engine idles one cycle with start low so it picks up eng_value.
            LOAD: begin
                eng_start_d = 1'b1;
                state_d     = RUN;
`ifdef BCARB_TIMEOUT_EN
                tmo_d       = '0;
`endif
            end
            RUN: begin
                if (bus.eng_done) begin
                    resp_result_d = bus.eng_result;
                    eng_start_d   = 1'b0;
                    state_d       = RELEASE;
                end
`ifdef BCARB_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
                    resp_result_d = '0;
                    eng_start_d   = 1'b0;
                    err_d         = 1'b1;
                    state_d       = RELEASE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            // Waiting for done low guarantees a fresh rise in the next RUN.
            RELEASE: begin
                eng_start_d = 1'b0;
                if (!bus.eng_done) begin
                    resp_valid_d = NUM_REQ'(1) << winner_q;
                    grant_d      = '0;
                    rr_ptr_d     = winner_q;
                    state_d      = IDLE;
`ifdef BCARB_TIMEOUT_EN
                    resp_err_d   = err_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            eng_start_q   <= 1'b0;
            eng_value_q   <= '0;
            rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
            winner_q      <= '0;
            busy_q        <= 1'b0;
`ifdef BCARB_TIMEOUT_EN
            tmo_q         <= '0;
            err_q         <= 1'b0;
            resp_err_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            eng_start_q   <= eng_start_d;
            eng_value_q   <= eng_value_d;
            rr_ptr_q      <= rr_ptr_d;
            winner_q      <= winner_d;
            busy_q        <= busy_d;
`ifdef BCARB_TIMEOUT_EN
            tmo_q         <= tmo_d;
            err_q         <= err_d;
            resp_err_q    <= resp_err_d;
`endif
        end
    end

    assign bus.grant       = grant_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = resp_result_q;
    assign bus.busy        = busy_q;
    assign bus.eng_start   = eng_start_q;
    assign bus.eng_value   = eng_value_q;
`ifdef BCARB_TIMEOUT_EN
    assign bus.resp_err    = resp_err_q;
`else
    assign bus.resp_err    = 1'b0;
`endif
endmodule

// File: tb/tb_bitcount_arbiter.sv
// Scoreboard bench for bitcount_arbiter with a behavioural shift-right bit-count engine.
module tb_bitcount_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int RES_W   = 4;
    localparam int TMO     = 32;

    typedef struct {
        int         idx;
        int         res;
        int         err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    logic [NUM_REQ-1:0] grant_prev = '0;

    logic              eng_never = 1'b0;
    logic [DATA_W-1:0] eng_val_l;
    int                eng_cnt;

    bitcount_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RES_W(RES_W)) bus ();

    bitcount_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Engine: loads while start is low, counts one bit per cycle, holds done until start drops.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.eng_done   <= 1'b0;
            bus.eng_result <= '0;
            eng_cnt        <= 0;
            eng_val_l      <= '0;
        end else if (!bus.eng_start) begin
            bus.eng_done <= 1'b0;
            eng_cnt      <= 0;
            eng_val_l    <= bus.eng_value;
        end else if (!bus.eng_done && !eng_never) begin
            if (eng_cnt == DATA_W - 1) begin
                bus.eng_done   <= 1'b1;
                bus.eng_result <= RES_W'($countones(eng_val_l));
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: grant legality on every new grant, scoreboard pop on every response.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.grant != '0) begin
                chk("grant_onehot", $countones(bus.grant), 1);
                if (grant_prev == '0) begin
                    if (exp_q.size() == 0) chk("grant_unexpected", int'(bus.grant), 0);
                    else chk("grant_idx", int'(bus.grant), 1 << exp_q[0].idx);
                end
            end
            if (bus.resp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", int'(bus.resp_valid), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_valid", int'(bus.resp_valid), 1 << e.idx);
                    chk("resp_result", int'(bus.resp_result), e.res);
                    chk("resp_err", int'(bus.resp_err), e.err);
                end
            end
        end
        grant_prev = bus.grant;
    end

    task automatic push(input int idx, input int res, input int err);
        exp_t e;
        e.idx = idx; e.res = res; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic set_data(input int i, input logic [DATA_W-1:0] v);
        bus.req_data[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.req = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_start(output int c);
        bit seen = 0;
        c = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (bus.eng_start) begin seen = 1; c = cyc; end
        end
        if (!seen) chk("start_timeout", 0, 1);
    endtask

    // Requester side: drop the served request in the same cycle as its response.
    task automatic wait_resp(output int c);
        bit seen = 0;
        c = 0;
        for (int k = 0; k < 500 && !seen; k++) begin
            @(negedge clk);
            if (bus.resp_valid != '0) begin
                seen = 1;
                c = cyc;
                bus.req = bus.req & ~bus.resp_valid;
            end
        end
        if (!seen) chk("resp_timeout", 0, 1);
    endtask

    initial begin
        int c0, c1;
        bus.req = '0;
        bus.req_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_resp_valid", int'(bus.resp_valid), 0);
        chk("rst_resp_result", int'(bus.resp_result), 0);
        chk("rst_resp_err", int'(bus.resp_err), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_eng_start", int'(bus.eng_start), 0);
        chk("rst_eng_value", int'(bus.eng_value), 0);
        reset = 1'b1;
        @(negedge clk);

        // Single requester.
        set_data(0, 8'h0F);
        push(0, 4, 0);
        bus.req = 4'b0001;
        wait_start(c0);
        chk("t1_busy_high", int'(bus.busy), 1);
        wait_resp(c1);
        @(negedge clk);
        chk("t1_busy_low", int'(bus.busy), 0);
        chk("t1_grant_clear", int'(bus.grant), 0);

        // All four together from reset: order 0,1,2,3.
        do_reset();
        set_data(0, 8'hFF); set_data(1, 8'h00); set_data(2, 8'h81); set_data(3, 8'h07);
        push(0, 8, 0); push(1, 0, 0); push(2, 2, 0); push(3, 3, 0);
        bus.req = 4'b1111;
        repeat (4) wait_resp(c1);

        // Requester 1 alone, then 1011: grants 3, 0, 1.
        set_data(1, 8'h55);
        push(1, 4, 0);
        bus.req = 4'b0010;
        wait_resp(c1);
        set_data(0, 8'h01); set_data(1, 8'hF0); set_data(3, 8'h7F);
        push(3, 7, 0); push(0, 1, 0); push(1, 4, 0);
        bus.req = 4'b1011;
        repeat (3) wait_resp(c1);

        // Reset during RUN drops the service silently.
        set_data(2, 8'hAA);
        push(2, 4, 0);
        bus.req = 4'b0100;
        wait_start(c0);
        reset = 1'b0;
        #1;
        chk("t4_eng_start", int'(bus.eng_start), 0);
        chk("t4_grant", int'(bus.grant), 0);
        chk("t4_busy", int'(bus.busy), 0);
        chk("t4_resp_valid", int'(bus.resp_valid), 0);
        bus.req = '0;
        void'(exp_q.pop_front());
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        set_data(2, 8'h3C);
        push(2, 4, 0);
        bus.req = 4'b0100;
        wait_resp(c1);

        // Request dropped during RUN is still answered.
        set_data(0, 8'h01);
        push(0, 1, 0);
        bus.req = 4'b0001;
        wait_start(c0);
        bus.req = '0;
        wait_resp(c1);

        // Engine that never finishes.
        eng_never = 1'b1;
        set_data(1, 8'hFF);
`ifdef BCARB_TIMEOUT_EN
        push(1, 0, 1);
        bus.req = 4'b0010;
        wait_start(c0);
        wait_resp(c1);
        chk("tmo_latency", c1 - c0, TMO + 2);
        eng_never = 1'b0;
`else
        push(1, 0, 0);
        bus.req = 4'b0010;
        wait_start(c0);
        repeat (TMO + 20) @(negedge clk);
        chk("hang_busy", int'(bus.busy), 1);
        chk("hang_eng_start", int'(bus.eng_start), 1);
        void'(exp_q.pop_front());
        eng_never = 1'b0;
        do_reset();
`endif

        // Engine still usable afterwards.
        set_data(3, 8'hE7);
        push(3, 6, 0);
        bus.req = 4'b1000;
        wait_resp(c1);

        repeat (10) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
